// File: rtl/pc_btb.sv
// pc_btb: fetch program counter with a direct-mapped branch target buffer.
// The BTB lookup is combinational on the current PC, so predictions have no added latency.
// Resolved branches write into the BTB and take effect from the following cycle.
module pc_btb #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0040_0000,
    parameter int              BTB_ENTRIES  = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc_out,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    // Instruction addresses are word aligned; the low two bits are always cleared.
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};

    // Saturating increment of a 2-bit direction counter.
    function automatic logic [1:0] ctr_sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    // Saturating decrement of a 2-bit direction counter.
    function automatic logic [1:0] ctr_sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    // BTB storage: valid and counters are control state, tag and target are data.
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [1:0]             ctr_q [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_q [BTB_ENTRIES];
    logic [XLEN-1:0]        tgt_q [BTB_ENTRIES];

    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  pc_nxt;

    logic [IDX-1:0]   up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    // The byte-offset bits of the update PC carry no information for an aligned fetch.
    logic unused_upd_lsbs;
    assign unused_upd_lsbs = ^upd_pc[1:0];

    assign lk_idx   = pc_out[IDX+1:2];
    assign lk_tag   = pc_out[XLEN-1:IDX+2];
    assign up_idx   = upd_pc[IDX+1:2];
    assign up_tag   = upd_pc[XLEN-1:IDX+2];
    assign pc_plus4 = pc_out + PC_STEP;

    // Lookup and update hit detection both read the BTB as it stands before this edge.
    always_comb begin
        lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        up_hit      = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
        pred_taken  = lk_hit && ctr_q[lk_idx][1];
        pred_target = lk_hit ? tgt_q[lk_idx] : pc_plus4;
    end

    // Next-PC select: redirect beats stall, stall beats prediction.
    always_comb begin
        pc_nxt = pc_plus4;
        if (redirect) begin
            pc_nxt = redirect_pc & ALIGN_MASK;
        end else if (stall) begin
            pc_nxt = pc_out;
        end else if (pred_taken) begin
            pc_nxt = pred_target;
        end
    end

    // Fetch PC register, forced to the reset vector while reset is low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_out <= RESET_VECTOR & ALIGN_MASK;
        end else begin
            pc_out <= pc_nxt;
        end
    end

    // Valid bits and direction counters: train on hit, allocate on a taken miss.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                ctr_q[i] <= 2'b00;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                ctr_q[up_idx] <= upd_taken ? ctr_sat_inc(ctr_q[up_idx])
                                           : ctr_sat_dec(ctr_q[up_idx]);
            end else if (upd_taken) begin
                valid_q[up_idx] <= 1'b1;
                ctr_q[up_idx]   <= 2'b10;
            end
        end
    end

    // Tag and target payload: written by every taken update, never cleared.
    always_ff @(posedge clock) begin
        if (reset && upd_valid && upd_taken) begin
            tag_q[up_idx] <= up_tag;
            tgt_q[up_idx] <= upd_target & ALIGN_MASK;
        end
    end

endmodule

// File: tb/tb_pc_btb.sv
// tb_pc_btb: scoreboard bench for pc_btb with a behavioural BTB/PC reference model.
module tb_pc_btb;

    localparam int        N  = 8;
    localparam int        SH = $clog2(N) + 2;
    localparam bit [31:0] RV = 32'h0040_0000;

    logic        clock = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] pc_out;
    logic        pred_taken;
    logic [31:0] pred_target;

    pc_btb #(.XLEN(32), .RESET_VECTOR(RV), .BTB_ENTRIES(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .pc_out      (pc_out),
        .pred_taken  (pred_taken),
        .pred_target (pred_target)
    );

    always #5 clock = ~clock;

    // Reference model: table of branch records plus the architectural fetch PC.
    typedef struct {
        bit        v;
        bit [31:0] tag;
        bit [31:0] tgt;
        int        ctr;
    } ent_t;

    typedef struct {
        bit [31:0] pc;
        bit        pt;
        bit [31:0] ptg;
        int        id;
    } exp_t;

    ent_t      m_btb [N];
    bit [31:0] m_pc;
    exp_t      sb [$];
    exp_t      e_m;
    int        tests = 0;
    int        fails = 0;
    int        step  = 0;

    function automatic int m_line(input bit [31:0] a);
        return int'((a >> 2) & 32'(N - 1));
    endfunction

    function automatic void m_reset();
        m_pc = RV;
        for (int i = 0; i < N; i++) begin
            m_btb[i].v   = 1'b0;
            m_btb[i].ctr = 0;
        end
    endfunction

    function automatic void m_predict(output bit pt, output bit [31:0] ptg);
        int i;
        bit hit;
        i   = m_line(m_pc);
        hit = m_btb[i].v && (m_btb[i].tag == (m_pc >> SH));
        pt  = hit && (m_btb[i].ctr >= 2);
        ptg = hit ? m_btb[i].tgt : m_pc + 32'd4;
    endfunction

    function automatic void m_step(input bit s, input bit r, input bit [31:0] rp,
                                   input bit uv, input bit [31:0] up, input bit ut,
                                   input bit [31:0] ug);
        bit        pt;
        bit [31:0] ptg;
        bit [31:0] nxt;
        int        i;
        m_predict(pt, ptg);
        if (r)       nxt = rp & ~32'd3;
        else if (s)  nxt = m_pc;
        else if (pt) nxt = ptg;
        else         nxt = m_pc + 32'd4;
        if (uv) begin
            i = m_line(up);
            if (m_btb[i].v && (m_btb[i].tag == (up >> SH))) begin
                if (ut) begin
                    m_btb[i].ctr = (m_btb[i].ctr == 3) ? 3 : m_btb[i].ctr + 1;
                    m_btb[i].tgt = ug & ~32'd3;
                end else begin
                    m_btb[i].ctr = (m_btb[i].ctr == 0) ? 0 : m_btb[i].ctr - 1;
                end
            end else if (ut) begin
                m_btb[i].v   = 1'b1;
                m_btb[i].tag = up >> SH;
                m_btb[i].tgt = ug & ~32'd3;
                m_btb[i].ctr = 2;
            end
        end
        m_pc = nxt;
    endfunction

    task automatic push_exp();
        exp_t e;
        bit        pt;
        bit [31:0] ptg;
        m_predict(pt, ptg);
        e.pc  = m_pc;
        e.pt  = pt;
        e.ptg = ptg;
        e.id  = step;
        sb.push_back(e);
        step++;
    endtask

    // One cycle: record the expected outputs for the current state, then drive inputs.
    task automatic drive(input bit s, input bit r, input bit [31:0] rp,
                         input bit uv, input bit [31:0] up, input bit ut,
                         input bit [31:0] ug);
        push_exp();
        stall       = s;
        redirect    = r;
        redirect_pc = rp;
        upd_valid   = uv;
        upd_pc      = up;
        upd_taken   = ut;
        upd_target  = ug;
        m_step(s, r, rp, uv, up, ut, ug);
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic go(input bit [31:0] a);
        drive(1'b0, 1'b1, a, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic upd(input bit [31:0] a, input bit t, input bit [31:0] g);
        drive(1'b0, 1'b0, 32'h0, 1'b1, a, t, g);
    endtask

    // Assert reset away from the clock edge, with a pending taken update that must be dropped.
    task automatic reset_pulse(input int n);
        reset = 1'b0;
        m_reset();
        for (int k = 0; k < n; k++) begin
            push_exp();
            redirect    = 1'b1;
            redirect_pc = 32'h0040_0080;
            upd_valid   = 1'b1;
            upd_taken   = 1'b1;
            upd_pc      = RV;
            upd_target  = 32'h0040_0200;
            @(posedge clock);
            #1;
        end
        redirect  = 1'b0;
        upd_valid = 1'b0;
        reset     = 1'b1;
    endtask

    function automatic bit [31:0] rand_addr();
        return RV + 32'($urandom_range(0, 47)) * 32'd4 + 32'($urandom_range(0, 3));
    endfunction

    function automatic void chk(input string name, input bit [31:0] act,
                                input bit [31:0] exp, input int id);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at step %0d: got %h, expected %h", name, id, act, exp);
        end
    endfunction

    // Monitor: every falling edge, pop one expectation and compare all outputs.
    always @(negedge clock) begin
        if (sb.size() != 0) begin
            e_m = sb.pop_front();
            chk("pc_out", pc_out, e_m.pc, e_m.id);
            chk("pred_taken", {31'b0, pred_taken}, {31'b0, e_m.pt}, e_m.id);
            chk("pred_target", pred_target, e_m.ptg, e_m.id);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        upd_valid   = 1'b0;
        upd_pc      = '0;
        upd_taken   = 1'b0;
        upd_target  = '0;
        m_reset();
        @(posedge clock);
        #1;
        reset_pulse(2);

        // Reset release, stall hold, redirect overriding stall.
        idle();
        idle();
        repeat (3) drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        drive(1'b1, 1'b1, 32'h0040_0103, 1'b0, 32'h0, 1'b0, 32'h0);
        idle();

        // Allocation and a predicted-taken visit.
        upd(32'h0040_0010, 1'b1, 32'h0040_0040);
        go(32'h0040_0010);
        idle();
        idle();

        // Counter walk.
        repeat (3) upd(32'h0040_0010, 1'b1, 32'h0040_0040);
        repeat (2) upd(32'h0040_0010, 1'b0, 32'h0);
        go(32'h0040_0010);
        idle();
        repeat (3) upd(32'h0040_0010, 1'b0, 32'h0);
        go(32'h0040_0010);
        idle();

        // Aliasing on a shared index.
        repeat (2) upd(32'h0040_0010, 1'b1, 32'h0040_0040);
        go(32'h0040_0030);
        idle();
        upd(32'h0040_0030, 1'b0, 32'h0);
        go(32'h0040_0010);
        idle();

        // Same-cycle lookup and update at the same index.
        go(32'h0040_0010);
        upd(32'h0040_0010, 1'b0, 32'h0);
        go(32'h0040_0010);
        idle();
        idle();

        // PC wrap through zero.
        go(32'hFFFF_FFF8);
        repeat (3) idle();

        // Randomized traffic with a reset pulse in the middle.
        for (int c = 0; c < 3000; c++) begin
            bit        s, r, uv, ut;
            bit [31:0] rp;
            if (c == 1500) reset_pulse(2);
            s  = ($urandom_range(0, 99) < 20);
            r  = ($urandom_range(0, 99) < 12);
            uv = ($urandom_range(0, 99) < 50);
            ut = ($urandom_range(0, 99) < 60);
            rp = ($urandom_range(0, 99) < 3) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                            : rand_addr();
            drive(s, r, rp, uv, rand_addr(), ut, rand_addr());
        end

        @(negedge clock);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_btb.md
PC_BTB -- requirements
Module: pc_btb

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC and target width.
REQ-002 SHALL have parameter RESET_VECTOR, default 32'h0040_0000: PC value after reset.
REQ-003 SHALL have parameter BTB_ENTRIES, default 8: direct-mapped BTB depth; power of two, minimum 2; IDX = log2(BTB_ENTRIES).
REQ-004 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port stall, input, 1: hold PC this cycle.
REQ-007 SHALL have port redirect, input, 1: execute-stage flush / mispredict correction.
REQ-008 SHALL have port redirect_pc, input, XLEN: correct next PC when redirect=1.
REQ-009 SHALL have port upd_valid, input, 1: resolved control-transfer update.
REQ-010 SHALL have port upd_pc, input, XLEN: PC of the resolved instruction.
REQ-011 SHALL have port upd_taken, input, 1: resolved direction.
REQ-012 SHALL have port upd_target, input, XLEN: resolved target.
REQ-013 SHALL have port pc_out, output, XLEN: current fetch PC (registered).
REQ-014 SHALL have port pred_taken, output, 1: BTB predicts pc_out taken.
REQ-015 SHALL have port pred_target, output, XLEN: predicted target for pc_out.

Function
REQ-016 Each BTB entry SHALL hold: valid; tag = pc[XLEN-1:IDX+2]; target[XLEN-1:0]; 2-bit saturating counter.
REQ-017 Lookup SHALL index by pc_out[IDX+1:2]; hit = valid && tag match; combinational from pc_out and current BTB state.
REQ-018 pred_taken SHALL be hit && ctr[1]; pred_target SHALL be the entry target on hit, else pc_out+4.
REQ-019 Next-PC priority, per edge: redirect -> redirect_pc; else stall -> hold; else pred_taken -> pred_target; else pc_out+4.
REQ-020 Redirect SHALL override stall in the same cycle.
REQ-021 pc_out[1:0] SHALL always be 2'b00; bits [1:0] of redirect_pc and upd_target SHALL be forced to zero on capture.
REQ-022 PC addition SHALL be modulo 2^XLEN; wrap from all-ones-minus-3 to 0 is legal and silent.
REQ-023 Update, when upd_valid, is indexed by upd_pc[IDX+1:2]. On hit: ctr increments if taken (saturating at 3), decrements if not taken (saturating at 0); target is rewritten only if taken.
REQ-024 Update on miss with upd_taken=1 SHALL allocate: valid=1, new tag, target, ctr=2'b10; miss with upd_taken=0 SHALL leave the entry unchanged.
REQ-025 Update SHALL apply regardless of stall or redirect.
REQ-026 Same-cycle lookup and update to the same index SHALL be read-before-write: the prediction uses pre-update state, and the update is visible from the next cycle.
REQ-027 Prediction latency SHALL be zero cycles; update-to-effect latency SHALL be one cycle.

Reset
REQ-028 While reset=0: pc_out=RESET_VECTOR, all valid=0, all ctr=2'b00, asynchronously and independent of clock.
REQ-029 Targets and tags need not be reset.
REQ-030 First rising edge after reset deasserts SHALL advance PC normally: pc_out=RESET_VECTOR+4 absent stall or redirect.
REQ-031 Reset asserted mid-update SHALL discard the update.

Verification
REQ-032 Reset release, no stall: pc_out sequence 0x00400000, 0x00400004, 0x00400008; pred_taken=0 throughout.
REQ-033 stall=1 for 3 cycles at pc_out=0x00400008 -> pc_out holds 3 cycles; redirect=1 with redirect_pc=0x00400103 and stall=1 -> pc_out=0x00400100 next cycle.
REQ-034 Update upd_pc=0x00400010, taken=1, target=0x00400040 -> next visit to 0x00400010: pred_taken=1, pred_target=0x00400040, following pc_out=0x00400040.
REQ-035 Counter walk: from ctr=2 apply taken x3 (saturates at 3), then not-taken x2 -> ctr=1, pred_taken=0; not-taken x3 more -> stays 0.
REQ-036 Aliasing, BTB_ENTRIES=8: entry allocated for 0x00400010; lookup at 0x00400030 (same index, different tag) -> pred_taken=0; not-taken update at 0x00400030 leaves the entry intact.
REQ-037 Same-cycle update and lookup at a matching index -> prediction reflects old state; reset pulse mid-run -> pc_out=0x00400000 immediately and all predictions cleared.
